ram_port_arbiter: RTL

- Shares one single-port RAMbus slave (data RAM at 0x2000, 0x2000 bytes) between two Ibex-style requesters: m0 is the instruction fetch port, m1 is the LSU data port.
- Each requester uses req/gnt/rvalid/err handshaking.
- The block arbitrates round-robin, keeps at most one transaction outstanding, and routes the response back to its owner.
- It also returns a bus error for out-of-window addresses and for RAM response timeouts.

---
 rtl/ram_port_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM slave.
// One transaction in flight; out-of-window accesses and RAM timeouts return a bus error.
module ram_port_arbiter #(
  parameter int          DW       = 32,
  parameter int          AW       = 32,
  parameter int          SW       = DW / 8,
  parameter logic [31:0] RAM_BASE = 32'h2000,
  parameter logic [31:0] RAM_SIZE = 32'h2000,
  parameter int          TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [SW-1:0] m0_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [SW-1:0] m1_be,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          ram_req,
  output logic          ram_we,
  output logic [SW-1:0] ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic          ram_rvalid,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] BASE     = AW'(RAM_BASE);
  localparam logic [AW-1:0] SIZE     = AW'(RAM_SIZE);
  // Timer value in the last WAIT cycle before the timeout response is launched
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  function automatic logic in_window(input logic [AW-1:0] addr);
    logic [AW-1:0] off;
    off = addr - BASE;
    return (addr >= BASE) && (off < SIZE);
  endfunction

  state_t        state;
  logic          owner;
  logic          last;
  logic          owner_we;
  logic          err_late;
  logic [TW-1:0] timer;

  logic [1:0]    vld_p1;
  logic [1:0]    err_p1;
  logic [DW-1:0] rdata0_p1;
  logic [DW-1:0] rdata1_p1;

  logic          grant_ok;
  logic          winner;
  logic          gnt;
  logic          sel_we;
  logic [SW-1:0] sel_be;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_in;

  logic          rsp_fire;
  logic          rsp_err;
  logic          rsp_to;
  logic [DW-1:0] rsp_data;

  always_comb begin
    winner    = (m0_req && m1_req) ? ~last : m1_req;
    grant_ok  = (state == IDLE) || ((state == WAIT) && ram_rvalid);
    gnt       = grant_ok && (m0_req || m1_req);
    sel_we    = winner ? m1_we    : m0_we;
    sel_be    = winner ? m1_be    : m0_be;
    sel_addr  = winner ? m1_addr  : m0_addr;
    sel_wdata = winner ? m1_wdata : m0_wdata;
    sel_in    = in_window(sel_addr);
  end

  assign m0_gnt    = gnt && !winner;
  assign m1_gnt    = gnt &&  winner;
  assign ram_req   = gnt && sel_in;
  assign ram_we    = ram_req && sel_we;
  assign ram_be    = ram_req ? sel_be            : '0;
  assign ram_addr  = ram_req ? (sel_addr - BASE) : '0;
  assign ram_wdata = ram_req ? sel_wdata         : '0;

  // An out-of-window grant taken back-to-back in WAIT would collide with the
  // RAM response leaving that same edge, so its error goes out one cycle later.
  always_comb begin
    rsp_fire = 1'b0;
    rsp_err  = 1'b0;
    rsp_to   = owner;
    rsp_data = '0;
    case (state)
      WAIT: begin
        if (ram_rvalid) begin
          rsp_fire = 1'b1;
          rsp_data = owner_we ? '0 : ram_rdata;
        end else if (timer == TMO_LAST) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
        end
      end
      ERR: begin
        rsp_fire = err_late;
        rsp_err  = err_late;
      end
      default: ;
    endcase
    if (gnt && !sel_in && (state == IDLE)) begin
      rsp_fire = 1'b1;
      rsp_err  = 1'b1;
      rsp_to   = winner;
    end
  end

  // p0 -> p1: response register and transaction control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      owner_we  <= 1'b0;
      err_late  <= 1'b0;
      timer     <= '0;
      vld_p1    <= '0;
      err_p1    <= '0;
      rdata0_p1 <= '0;
      rdata1_p1 <= '0;
    end else begin
      vld_p1 <= '0;
      err_p1 <= '0;
      if (rsp_fire) begin
        vld_p1[rsp_to] <= 1'b1;
        err_p1[rsp_to] <= rsp_err;
        if (rsp_to) rdata1_p1 <= rsp_data;
        else        rdata0_p1 <= rsp_data;
      end

      case (state)
        WAIT: begin
          timer <= timer + 1'b1;
          if (ram_rvalid || (timer == TMO_LAST)) state <= IDLE;
        end
        ERR: begin
          state    <= IDLE;
          err_late <= 1'b0;
        end
        default: ;
      endcase

      if (gnt) begin
        owner    <= winner;
        last     <= winner;
        owner_we <= sel_we;
        timer    <= '0;
        if (sel_in) begin
          state <= WAIT;
        end else begin
          state    <= ERR;
          err_late <= (state == WAIT);
        end
      end
    end
  end

  assign m0_rvalid = vld_p1[0];
  assign m1_rvalid = vld_p1[1];
  assign m0_err    = err_p1[0];
  assign m1_err    = err_p1[1];
  assign m0_rdata  = rdata0_p1;
  assign m1_rdata  = rdata1_p1;

endmodule
